// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller, pipeline and debug unit:
// state encodings, command codes and the program terminator word.
package fetch_controller_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_PAUSE  = 3'd3;
  localparam logic [2:0] ST_STEP   = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_RUN  = 2'b10,
    CMD_STEP = 2'b11
  } cmd_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic pc_enable;
    logic pc_reset;
  } pc_ctrl_t;

  // PC only advances while executing; it is pinned at 0 until a program is loaded.
  function automatic pc_ctrl_t pc_ctrl(input logic [2:0] state);
    pc_ctrl_t ctrl;
    ctrl.pc_enable = (state == ST_RUN) || (state == ST_STEP);
    ctrl.pc_reset  = (state == ST_IDLE) || (state == ST_LOAD);
    return ctrl;
  endfunction

endpackage

// File: rtl/fetch_controller_word_assembler.sv
// Packs serial program bytes MSB-first into instruction words and strobes
// word_valid for one cycle, the cycle after the last byte is sampled.
module word_assembler
  import fetch_controller_pkg::*;
#(
  parameter int len = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           byte_valid,
  input  logic [7:0]     byte_data,
  output logic           word_valid,
  output logic [len-1:0] word
);

  localparam int BPW = len / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

  logic [CW-1:0]  byte_count;
  logic [len-9:0] shift_reg;
  logic [len-1:0] shifted;

  // Earlier bytes already sit in shift_reg, so the incoming byte lands at the bottom.
  assign shifted = {shift_reg, byte_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_count <= '0;
      shift_reg  <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_count <= '0;
        shift_reg  <= '0;
      end else if (byte_valid) begin
        shift_reg <= shifted[len-9:0];
        if (byte_count == LAST_BYTE) begin
          byte_count <= '0;
          word_valid <= 1'b1;
          word       <= shifted;
        end else begin
          byte_count <= byte_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Top-level fetch sequencer: loads a program from the serial receiver into
// instruction memory and gates the PC for run / single-step execution.
//
// state  | meaning
// IDLE   | no program activity, PC held at 0
// LOAD   | assembling received bytes and writing instruction memory
// RUN    | free-running execution until halt retires
// PAUSE  | execution suspended, waiting for run or step
// STEP   | single cycle of execution
// HALTED | halt instruction retired, only a new load is accepted
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int len       = 32,
  parameter int RAM_DEPTH = 2048
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     in_rx_data,
  input  logic           in_rx_valid,
  input  logic [1:0]     in_cmd,
  input  logic           in_cmd_valid,
  input  logic           in_halt_detected,
  output logic           out_pc_enable,
  output logic           out_pc_reset,
  output logic           out_wr_en,
  output logic [len-1:0] out_wr_addr,
  output logic [len-1:0] out_wr_data,
  output logic [2:0]     out_state,
  output logic           out_load_done,
  output logic           out_step_done
);

  localparam logic [len-1:0] LAST_ADDR  = len'(4 * (RAM_DEPTH - 1));
  localparam logic [len-1:0] HALT_VALUE = len'(HALT_WORD);

  logic [2:0] state;
  logic [2:0] next_state;
  cmd_t       cmd;
  logic       load_end;
  logic       load_entry;
  logic       asm_byte_valid;
  pc_ctrl_t   ctrl;

  assign cmd = cmd_t'(in_cmd);

  // A load finishes on the write of the terminator word or of the last memory slot.
  assign load_end   = out_wr_en && ((out_wr_data == HALT_VALUE) || (out_wr_addr == LAST_ADDR));
  assign load_entry = (next_state == ST_LOAD) && (state != ST_LOAD);

  assign asm_byte_valid = in_rx_valid && (state == ST_LOAD);

  word_assembler #(
    .len (len)
  ) u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_entry),
    .byte_valid (asm_byte_valid),
    .byte_data  (in_rx_data),
    .word_valid (out_wr_en),
    .word       (out_wr_data)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (in_cmd_valid) begin
          case (cmd)
            CMD_LOAD: next_state = ST_LOAD;
            CMD_RUN:  next_state = ST_RUN;
            CMD_STEP: next_state = ST_STEP;
            default:  next_state = state;
          endcase
        end
      end
      ST_LOAD: begin
        if (load_end) next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (in_halt_detected) next_state = ST_HALTED;
      end
      ST_STEP: begin
        next_state = in_halt_detected ? ST_HALTED : ST_PAUSE;
      end
      ST_PAUSE: begin
        if (in_halt_detected) begin
          next_state = ST_HALTED;
        end else if (in_cmd_valid) begin
          case (cmd)
            CMD_RUN:  next_state = ST_RUN;
            CMD_STEP: next_state = ST_STEP;
            default:  next_state = state;
          endcase
        end
      end
      ST_HALTED: begin
        if (in_cmd_valid && (cmd == CMD_LOAD)) next_state = ST_LOAD;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      out_wr_addr   <= '0;
      out_load_done <= 1'b0;
      out_step_done <= 1'b0;
    end else begin
      state         <= next_state;
      out_load_done <= (state == ST_LOAD) && load_end;
      out_step_done <= (state == ST_STEP) && !in_halt_detected;
      // The final slot's address is held rather than wrapped back to 0.
      if (load_entry) begin
        out_wr_addr <= '0;
      end else if (out_wr_en && (out_wr_addr != LAST_ADDR)) begin
        out_wr_addr <= out_wr_addr + len'(4);
      end
    end
  end

  assign ctrl          = pc_ctrl(state);
  assign out_pc_enable = ctrl.pc_enable;
  assign out_pc_reset  = ctrl.pc_reset;
  assign out_state     = state;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter len, default 32, meaning the width of instruction words and PC addresses.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 2048, meaning the instruction-memory depth in words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_rx_data, input, 8 bits: program byte from the serial receiver.
REQ-006 The block SHALL have port in_rx_valid, input, 1 bit: one-cycle strobe qualifying in_rx_data.
REQ-007 The block SHALL have port in_cmd, input, 2 bits: command code (00 none, 01 load, 10 run, 11 step).
REQ-008 The block SHALL have port in_cmd_valid, input, 1 bit: one-cycle strobe qualifying in_cmd.
REQ-009 The block SHALL have port in_halt_detected, input, 1 bit: pipeline reports that the halt instruction has retired.
REQ-010 The block SHALL have port out_pc_enable, output, 1 bit: PC register update enable.
REQ-011 The block SHALL have port out_pc_reset, output, 1 bit: holds the PC at 0.
REQ-012 The block SHALL have port out_wr_en, output, 1 bit: instruction-memory write strobe.
REQ-013 The block SHALL have port out_wr_addr, output, len bits: instruction-memory byte address, word-aligned.
REQ-014 The block SHALL have port out_wr_data, output, len bits: instruction word to write.
REQ-015 The block SHALL have port out_state, output, 3 bits: current state encoding.
REQ-016 The block SHALL have port out_load_done, output, 1 bit: one-cycle pulse marking the end of a load.
REQ-017 The block SHALL have port out_step_done, output, 1 bit: one-cycle pulse after each executed step.

Function
REQ-018 The FSM SHALL implement states IDLE=0, LOAD=1, RUN=2, PAUSE=3, STEP=4, HALTED=5; a state change is visible on out_state one cycle after the sampling edge.
REQ-019 The FSM SHALL make these transitions on cmd: IDLE: load->LOAD, run->RUN, step->STEP; PAUSE: run->RUN, step->STEP; HALTED: load->LOAD; in all other state/command pairs the command SHALL be ignored.
REQ-020 STEP SHALL last exactly one cycle, then go to PAUSE with out_step_done pulsed high for the first PAUSE cycle.
REQ-021 in_halt_detected high in RUN, STEP or PAUSE SHALL move the FSM to HALTED on the next edge, with priority over any simultaneous command.
REQ-022 out_pc_enable SHALL be 1 only in RUN and STEP.
REQ-023 out_pc_reset SHALL be 1 only in IDLE and LOAD.
REQ-024 In LOAD, bytes SHALL be assembled MSB-first: the first byte goes to bits [31:24] and the fourth byte completes the word.
REQ-025 out_wr_en SHALL pulse for one cycle, the cycle after the edge sampling the fourth byte, carrying the assembled word in out_wr_data and the address in out_wr_addr.
REQ-026 out_wr_addr SHALL start at 0 on LOAD entry and advance by 4 after each write.
REQ-027 If a written word equals HALT_WORD (0xFFFFFFFF), the FSM SHALL return to IDLE after that write and pulse out_load_done.
REQ-028 Writing address 4*(RAM_DEPTH-1) SHALL also end the load (IDLE + out_load_done); the address SHALL never wrap.
REQ-029 in_rx_valid outside LOAD SHALL be ignored.
REQ-030 in_cmd_valid during LOAD SHALL be ignored.
REQ-031 On LOAD entry, partial-byte state SHALL be cleared.
REQ-032 in_rx_valid and in_cmd_valid asserted in the same cycle SHALL each be handled per their own state rules.

Reset
REQ-033 reset SHALL force: state IDLE, out_pc_reset=1, out_pc_enable=0, out_wr_en=0, out_wr_addr=0, out_wr_data=0, byte counter=0, out_load_done=0, out_step_done=0.
REQ-034 reset SHALL take priority over all other inputs, including mid-load, which SHALL abandon the partial word with no write.

Structure
REQ-035 State encodings, command codes and HALT_WORD SHALL reside in a shared package/header used by the pipeline and debug unit.
REQ-036 Byte-to-word assembly SHALL be a sub-module, word_assembler (byte counter, shift register, word-valid strobe); the FSM and address counter SHALL stay in fetch_controller.

Verification
REQ-037 Reset then load of bytes 20,01,00,05, 8C,22,00,00, FF,FF,FF,FF SHALL produce writes (0x0,0x20010005), (0x4,0x8C220000), (0x8,0xFFFFFFFF), followed by out_load_done and out_state=IDLE.
REQ-038 After load, run SHALL give out_pc_enable=1 each cycle until in_halt_detected, then HALTED with out_pc_enable=0 next cycle.
REQ-039 Three step commands from IDLE SHALL give exactly three single-cycle out_pc_enable pulses, each followed by out_step_done, with state PAUSE between them.
REQ-040 reset after two bytes of a word, then a new load of 4 bytes, SHALL write the new word at address 0 only.
REQ-041 With RAM_DEPTH=4 and 16 non-halt bytes, writes SHALL go to 0x0, 0x4, 0x8, 0xC and the load SHALL end with out_load_done, no wrap to 0.
REQ-042 A run command during LOAD, and halt+step in the same PAUSE cycle, SHALL be respectively ignored and resolved to HALTED.
